// File: rtl/gpu2d_video_pkg.sv
// Shared video-pipeline definitions: the scanline-fill state encoding and the
// default display geometry that the timing generator also uses.
package gpu2d_video_pkg;

  localparam int LINE_PIXELS = 800;
  localparam int V_PIXELS    = 600;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL
  } fill_state_t;

  // Saturating 8-bit increment for event counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/scanline_fill_ctrl_if.sv
// Renderer-side handshake of the scanline fill controller: the line request
// channel, the pixel stream and the abort pulse.
interface scanline_fill_ctrl_if #(
  parameter int LINE_WIDTH = 10,
  parameter int DATA_WIDTH = 8
);

  logic                  req_valid;
  logic [LINE_WIDTH-1:0] req_line;
  logic                  req_ready;
  logic                  px_valid;
  logic [DATA_WIDTH-1:0] px_data;
  logic                  px_ready;
  logic                  line_abort;

  modport master (
    output req_valid,
    output req_line,
    input  req_ready,
    input  px_valid,
    input  px_data,
    output px_ready,
    output line_abort
  );

  modport slave (
    input  req_valid,
    input  req_line,
    output req_ready,
    output px_valid,
    output px_data,
    input  px_ready,
    input  line_abort
  );

endinterface

// File: rtl/scanline_fill_ctrl.sv
// Ping-pong scanline fill scheduler: requests the next line from the renderer
// and streams its pixels into the even or odd buffer not being displayed.
module scanline_fill_ctrl #(
  parameter int LINE_PIXELS = gpu2d_video_pkg::LINE_PIXELS,
  parameter int V_PIXELS    = gpu2d_video_pkg::V_PIXELS,
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int LINE_WIDTH  = $clog2(V_PIXELS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vblank_start,
  input  logic                  line_start,
  input  logic [LINE_WIDTH-1:0] line_index,
  scanline_fill_ctrl_if.master  render,
  output logic                  even_wren,
  output logic                  odd_wren,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  fill_done,
  output logic [7:0]            underrun_count
);

  localparam logic [LINE_WIDTH-1:0] LAST_LINE = LINE_WIDTH'(V_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PX   = ADDR_WIDTH'(LINE_PIXELS - 1);
  // One bit wider so LINE_PIXELS == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0]   PIX_LIMIT = (ADDR_WIDTH + 1)'(LINE_PIXELS);

  gpu2d_video_pkg::fill_state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] pix_cnt;
  logic [LINE_WIDTH-1:0] line_q;
  logic [LINE_WIDTH-1:0] target_line;
  logic                  line_abort_q;
  logic                  trigger;
  logic                  abort;
  logic                  px_ready_int;
  logic                  accept;
  logic                  last_px;

  // The last visible line has no successor, so it never starts a fill.
  assign trigger     = vblank_start || (line_start && (line_index < LAST_LINE));
  assign target_line = vblank_start ? '0 : line_index + LINE_WIDTH'(1);
  assign abort       = trigger && (state != gpu2d_video_pkg::IDLE);

  assign px_ready_int = (state == gpu2d_video_pkg::FILL) && ({1'b0, pix_cnt} < PIX_LIMIT);
  assign accept       = render.px_valid && px_ready_int;
  assign last_px      = accept && (pix_cnt == LAST_PX);

  assign render.req_valid  = (state == gpu2d_video_pkg::REQ);
  assign render.req_line   = line_q;
  assign render.px_ready   = px_ready_int;
  assign render.line_abort = line_abort_q;

  always_comb begin
    // NOTE: default first, so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      gpu2d_video_pkg::REQ:  if (render.req_ready) state_nxt = gpu2d_video_pkg::FILL;
      gpu2d_video_pkg::FILL: if (last_px)          state_nxt = gpu2d_video_pkg::IDLE;
      default:               state_nxt = state;
    endcase
    // A new line always restarts the sequence, whatever was in flight.
    if (trigger) state_nxt = gpu2d_video_pkg::REQ;
  end

  // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= gpu2d_video_pkg::IDLE;
      pix_cnt        <= '0;
      line_q         <= '0;
      line_abort_q   <= 1'b0;
      even_wren      <= 1'b0;
      odd_wren       <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      fill_done      <= 1'b0;
      underrun_count <= 8'd0;
    end else begin
      state        <= state_nxt;
      line_abort_q <= abort;

      // A pixel accepted in an abort cycle still lands, in the old buffer.
      even_wren <= accept && !line_q[0];
      odd_wren  <= accept &&  line_q[0];
      fill_done <= last_px;
      if (accept) begin
        wr_addr <= pix_cnt;
        wr_data <= render.px_data;
      end

      if (trigger) begin
        line_q  <= target_line;
        pix_cnt <= '0;
      end else if (accept) begin
        pix_cnt <= pix_cnt + ADDR_WIDTH'(1);
      end

      if (vblank_start) begin
        underrun_count <= 8'd0;
      end else if (abort) begin
        underrun_count <= gpu2d_video_pkg::sat_inc8(underrun_count);
      end
    end
  end

endmodule

// File: doc/scanline_fill_ctrl.md
# scanline_fill_ctrl

Scheduler that keeps the two scanline buffers (even/odd VRAM) fed for the video timing generator. While one buffer is being displayed, it fills the other with the next line. It requests that line from the renderer and streams the renderer's pixels into the correct buffer's write port. It detects late fills (underruns) and tells the renderer to abandon a stale line.

## Interface
Parameters:
- LINE_PIXELS, 800, pixels written per scanline
- V_PIXELS, 600, visible lines per frame
- ADDR_WIDTH, 10, scanline buffer address width
- DATA_WIDTH, 8, pixel width
- LINE_WIDTH, $clog2(V_PIXELS), line-number width

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  reset; synchronous, active-low
- vblank_start  in  1  one-cycle pulse at start of vertical blank
- line_start  in  1  one-cycle pulse when visible line line_index begins display
- line_index  in  LINE_WIDTH  line being displayed, valid with line_start
- req_valid  out  1  line request to renderer
- req_line  out  LINE_WIDTH  requested line number
- req_ready  in  1  renderer accepts request
- px_valid  in  1  renderer pixel valid
- px_data  in  DATA_WIDTH  renderer pixel
- px_ready  out  1  controller accepts pixel
- line_abort  out  1  one-cycle pulse; renderer drops the current line
- even_wren  out  1  write enable, even buffer
- odd_wren  out  1  write enable, odd buffer
- wr_addr  out  ADDR_WIDTH  shared write address
- wr_data  out  DATA_WIDTH  shared write data
- fill_done  out  1  one-cycle pulse with the last pixel write of a line
- underrun_count  out  8  saturating count of aborted fills, cleared on vblank_start

## Operation
- States:
  - IDLE
  - REQ (req_valid=1)
  - FILL (px_ready=1 while pix_cnt < LINE_PIXELS)
- Triggers:
  - vblank_start: target line = 0.
  - line_start with line_index = L < V_PIXELS-1: target line = L+1.
  - line_start with L = V_PIXELS-1: no trigger.
- Target buffer parity = target line bit 0 (0 = even, 1 = odd).
- On a trigger from any state:
  - latch target line and parity, clear pix_cnt, go to REQ.
- Trigger while in REQ or FILL (previous fill incomplete):
  - pulse line_abort
  - increment underrun_count, saturating at 255
  - then restart as above
- Trigger counting:
  - vblank_start and line_start in the same cycle: vblank_start wins, and only one trigger is counted.
  - A vblank_start abort clears underrun_count instead of incrementing it; the clear wins.
- REQ: hold req_valid and req_line stable until req_ready; on req_valid&&req_ready go to FILL.
- FILL, each px_valid&&px_ready:
  - write px_data at address pix_cnt into the target buffer only (even_wren XOR odd_wren)
  - pix_cnt++
- The accept with pix_cnt = LINE_PIXELS-1 is the last one:
  - go to IDLE
  - px_ready falls the next cycle
- px_valid outside FILL is ignored; no write occurs.
- Arithmetic: pix_cnt is ADDR_WIDTH bits; LINE_PIXELS ≤ 2^ADDR_WIDTH. The target line is computed at LINE_WIDTH bits and never wraps, because line V_PIXELS-1 does not trigger.

## Timing
- Reset (rst_n=0 at a clk edge):
  - state IDLE
  - req_valid, px_ready, line_abort, even_wren, odd_wren, fill_done all 0
  - wr_addr, wr_data, req_line, underrun_count all 0
- Reset mid-fill: same as above; no abort pulse.
- Trigger at cycle t:
  - req_valid=1 and req_line valid at t+1
  - line_abort (if any) at t+1
- Request accepted at cycle t: px_ready=1 from t+1.
- Pixel accepted at cycle t:
  - wren, wr_addr, wr_data registered and valid at t+1
  - last pixel: fill_done at t+1 with the final write
- Abort at trigger cycle t:
  - no write from the old fill occurs at t+1 or later, except the registered write of a pixel accepted at t, which lands in the old buffer
- Throughput: one pixel per cycle with px_valid held high. A full line takes LINE_PIXELS+2 cycles from trigger to fill_done, given req_ready=1 immediately.

## Structure
- Shared package gpu2d_video_pkg:
  - fill_state_t enum {IDLE, REQ, FILL}
  - default timing constants LINE_PIXELS and V_PIXELS, shared with the video timing generator
- Single module, no sub-module: the FSM, pixel counter and write register are tightly coupled.

## Test plan
- Reset then vblank_start:
  - req_valid with req_line=0 next cycle
  - after req_ready and 800 continuous pixels with data = addr[7:0]: even_wren writes at addresses 0..799, odd_wren never high, fill_done coincides with the addr-799 write
- line_start, line_index=4:
  - req_line=5, only odd_wren writes
- line_start, line_index=599:
  - no req_valid, state stays IDLE
- Renderer stalls: px_valid toggling 1/0, req_ready delayed 10 cycles:
  - exactly 800 writes, addresses contiguous, req_line stable during stall
- line_start arrives at pixel 400 of a fill:
  - line_abort pulse
  - underrun_count=1
  - new request issued
  - no writes after one registered write of a pixel accepted in the trigger cycle
  - a following vblank_start clears the count to 0
- rst_n low mid-fill:
  - all outputs zero next cycle
  - a subsequent vblank_start fill completes normally
